// File: rtl/prio_sel_arb_pkg.sv
// Shared types, widths and bit helpers for the prio_sel_arb priority selector.
// Helpers work on 32-bit vectors, so channel counts up to 32 are supported.
package prio_sel_pkg;

    typedef enum logic {
        PS_FIXED = 1'b0,
        PS_RR    = 1'b1
    } ps_mode_e;

    localparam int ERR_CNT_W = 8;

    function automatic logic [31:0] onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

    function automatic int unsigned countones(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_sel_arb_if.sv
// Request/data bundle between the sources and the priority selector.
// The master drives requests and data; the slave (the arbiter) returns the selection.
interface prio_sel_arb_if
    import prio_sel_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]         en;
    logic [N*W-1:0]       din;
    logic                 lock;
    logic                 chk_en;
    logic [W-1:0]         y;
    logic                 y_vld;
    logic [N-1:0]         gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 none_err;
    logic                 multi_en;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output en, din, lock, chk_en,
        input  y, y_vld, gnt, gnt_idx, none_err, multi_en, err_cnt
    );

    modport slave (
        input  en, din, lock, chk_en,
        output y, y_vld, gnt, gnt_idx, none_err, multi_en, err_cnt
    );

endinterface

// File: rtl/prio_sel_rr_pick.sv
// Combinational rotating priority encoder: first set bit of en at or after ptr,
// wrapping N-1 -> 0. With ptr tied to zero it is a plain lowest-index-wins encoder.
module prio_sel_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  en,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] sel,
    output logic          any
);

    int idx;

    // Walk offsets from farthest to nearest so the closest request to ptr is the last write.
    always_comb begin
        sel = '0;
        any = |en;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en[idx]) begin
                sel = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/prio_sel_arb.sv
// N-channel priority selector/arbiter with registered data, grant and error flags.
// MODE 0 = fixed priority (channel 0 highest), MODE 1 = round-robin.
module prio_sel_arb
    import prio_sel_pkg::*;
#(
    parameter int N    = 3,
    parameter int W    = 8,
    parameter int MODE = 0
) (
    input logic         clk,
    input logic         rst_n,
    prio_sel_arb_if.slave bus
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [W-1:0]         din_arr [N];
    logic [W-1:0]         y_reg;
    logic                 y_vld_reg;
    logic [N-1:0]         gnt_reg;
    logic [IW-1:0]        gnt_idx_reg;
    logic [IW-1:0]        ptr_reg;
    logic                 none_err_reg;
    logic                 multi_en_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_sel;
    logic          pick_any;
    logic          lock_hold;
    logic          grant;
    logic [IW-1:0] sel;
    logic [31:0]   sel_oh;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign din_arr[gi] = bus.din[gi*W +: W];
        end
    endgenerate

    assign pick_ptr = (MODE == int'(PS_RR)) ? ptr_reg : '0;

    prio_sel_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .en  (bus.en),
        .ptr (pick_ptr),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Lock only holds while the currently granted channel keeps requesting.
    assign lock_hold = bus.lock & (|(gnt_reg & bus.en));
    assign sel       = lock_hold ? gnt_idx_reg : pick_sel;
    assign grant     = lock_hold | pick_any;
    assign sel_oh    = onehot(32'(sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg        <= '0;
            y_vld_reg    <= 1'b0;
            gnt_reg      <= '0;
            gnt_idx_reg  <= '0;
            ptr_reg      <= '0;
            none_err_reg <= 1'b0;
            multi_en_reg <= 1'b0;
            err_cnt_reg  <= '0;
        end else begin
            multi_en_reg <= (countones(32'(bus.en)) > 1);
            if (grant) begin
                y_reg        <= din_arr[sel];
                y_vld_reg    <= 1'b1;
                gnt_reg      <= sel_oh[N-1:0];
                gnt_idx_reg  <= sel;
                none_err_reg <= 1'b0;
                if (!lock_hold) begin
                    ptr_reg <= (sel == LAST) ? '0 : sel + 1'b1;
                end
            end else begin
                // y keeps its last granted word; gnt_idx is only meaningful with y_vld.
                gnt_reg      <= '0;
                y_vld_reg    <= 1'b0;
                none_err_reg <= bus.chk_en;
                if (bus.chk_en && (err_cnt_reg != '1)) begin
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.y        = y_reg;
    assign bus.y_vld    = y_vld_reg;
    assign bus.gnt      = gnt_reg;
    assign bus.gnt_idx  = gnt_idx_reg;
    assign bus.none_err = none_err_reg;
    assign bus.multi_en = multi_en_reg;
    assign bus.err_cnt  = err_cnt_reg;

endmodule
